// File: rtl/laser_cover_check_if.sv
// Snoop/result bundle between the laser search engine and the cover scorer.
// The slave modport is the scorer's view; master is the engine/consumer side.
interface laser_cover_check_if #(
  parameter int unsigned N_TGT = 40
);
  localparam int unsigned CntW = $clog2(N_TGT + 1);

  logic             i_tgt_valid;
  logic [3:0]       i_x;
  logic [3:0]       i_y;
  logic             i_done;
  logic [3:0]       i_c1x;
  logic [3:0]       i_c1y;
  logic [3:0]       i_c2x;
  logic [3:0]       i_c2y;
  logic             i_res_ready;
  logic             o_res_valid;
  logic [CntW-1:0]  o_hit_cnt;
  logic [N_TGT-1:0] o_hit_mask;
  logic             o_busy;
  logic             o_err;

  modport master (
    output i_tgt_valid, i_x, i_y, i_done, i_c1x, i_c1y, i_c2x, i_c2y, i_res_ready,
    input  o_res_valid, o_hit_cnt, o_hit_mask, o_busy, o_err
  );

  modport slave (
    input  i_tgt_valid, i_x, i_y, i_done, i_c1x, i_c1y, i_c2x, i_c2y, i_res_ready,
    output o_res_valid, o_hit_cnt, o_hit_mask, o_busy, o_err
  );
endinterface

// File: rtl/laser_cover_check.sv
// Two-circle cover scorer: double-buffered target snoop, per-frame re-score against the
// latched circle centres, count + hit mask presented on a valid/ready result port.
module laser_cover_check #(
  parameter int unsigned N_TGT = 40,
  parameter int unsigned R2    = 16,
  parameter int unsigned LANES = 1
) (
  input logic                i_clk,
  input logic                i_rst_n,
  laser_cover_check_if.slave bus
);
  localparam int unsigned CntW    = $clog2(N_TGT + 1);
  localparam int unsigned IdxW    = $clog2(N_TGT);
  localparam int unsigned LastIdx = N_TGT - LANES;

  typedef enum logic [1:0] {StIdle, StScore, StHold} state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [7:0]       r_store [2][N_TGT];
  logic             r_load_bank;
  logic             r_score_bank;
  logic [CntW-1:0]  r_wr_cnt;
  logic [CntW-1:0]  w_wr_cnt_d;
  logic [IdxW-1:0]  r_rd_idx;
  logic [CntW-1:0]  r_acc;
  logic [N_TGT-1:0] r_mask;
  logic [3:0]       r_c1x;
  logic [3:0]       r_c1y;
  logic [3:0]       r_c2x;
  logic [3:0]       r_c2y;
  logic [CntW-1:0]  r_hit_cnt;
  logic [N_TGT-1:0] r_hit_mask;
  logic             r_err;

  logic             w_full;
  logic             w_hold_ack;
  logic             w_done_ok;
  logic             w_err_d;
  logic             w_wr_en;
  logic             w_wr_bank;
  logic [IdxW-1:0]  w_wr_slot;
  logic             w_last;
  logic [IdxW-1:0]  w_idx;
  logic [7:0]       w_ent;
  logic             w_hit;
  logic [CntW-1:0]  w_lane_hits;
  logic [N_TGT-1:0] w_mask_d;

  function automatic logic in_circle(input logic [3:0] cx, input logic [3:0] cy,
                                     input logic [3:0] px, input logic [3:0] py);
    logic [3:0] dx;
    logic [3:0] dy;
    logic [7:0] sqx;
    logic [7:0] sqy;
    logic [8:0] sum;
    dx  = (cx >= px) ? (cx - px) : (px - cx);
    dy  = (cy >= py) ? (cy - py) : (py - cy);
    sqx = 8'(dx) * 8'(dx);
    sqy = 8'(dy) * 8'(dy);
    sum = 9'(sqx) + 9'(sqy);
    return (sum <= 9'(R2));
  endfunction

  // Write-before-check: fullness is judged on the count before this cycle's write.
  assign w_full     = (r_wr_cnt == CntW'(N_TGT));
  assign w_hold_ack = (r_state == StHold) && bus.i_res_ready;
  assign w_done_ok  = bus.i_done && w_full && ((r_state == StIdle) || w_hold_ack);
  assign w_err_d    = (bus.i_done && !w_done_ok) || (bus.i_tgt_valid && w_full && !w_done_ok);
  // A target arriving with an accepted DONE opens the freshly swapped load bank.
  assign w_wr_en    = bus.i_tgt_valid && (w_done_ok || !w_full);
  assign w_wr_bank  = w_done_ok ? ~r_load_bank : r_load_bank;
  assign w_wr_slot  = w_done_ok ? '0 : IdxW'(r_wr_cnt);
  assign w_last     = (r_rd_idx == IdxW'(LastIdx));

  always_comb begin
    w_wr_cnt_d = r_wr_cnt;
    if (w_done_ok) begin
      w_wr_cnt_d = bus.i_tgt_valid ? CntW'(1) : '0;
    end else if (w_wr_en) begin
      w_wr_cnt_d = r_wr_cnt + CntW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_store[w_wr_bank][w_wr_slot] <= {bus.i_x, bus.i_y};
    end
  end

  // One group of LANES targets per SCORE cycle; OR of both circles so overlap counts once.
  always_comb begin
    w_lane_hits = '0;
    w_mask_d    = r_mask;
    w_idx       = '0;
    w_ent       = '0;
    w_hit       = 1'b0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_idx = r_rd_idx + IdxW'(l);
      w_ent = r_store[r_score_bank][w_idx];
      w_hit = in_circle(r_c1x, r_c1y, w_ent[7:4], w_ent[3:0]) ||
              in_circle(r_c2x, r_c2y, w_ent[7:4], w_ent[3:0]);
      w_lane_hits = w_lane_hits + CntW'(w_hit);
      if (w_hit) begin
        w_mask_d[w_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_done_ok) w_state_d = StScore;
      end
      StScore: begin
        if (w_last) w_state_d = StHold;
      end
      StHold: begin
        if (w_done_ok) begin
          w_state_d = StScore;
        end else if (bus.i_res_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_load_bank  <= 1'b0;
      r_score_bank <= 1'b0;
      r_wr_cnt     <= '0;
      r_rd_idx     <= '0;
      r_acc        <= '0;
      r_mask       <= '0;
      r_c1x        <= '0;
      r_c1y        <= '0;
      r_c2x        <= '0;
      r_c2y        <= '0;
      r_hit_cnt    <= '0;
      r_hit_mask   <= '0;
      r_err        <= 1'b0;
    end else begin
      r_err    <= w_err_d;
      r_wr_cnt <= w_wr_cnt_d;
      if (w_done_ok) begin
        r_c1x        <= bus.i_c1x;
        r_c1y        <= bus.i_c1y;
        r_c2x        <= bus.i_c2x;
        r_c2y        <= bus.i_c2y;
        r_score_bank <= r_load_bank;
        r_load_bank  <= ~r_load_bank;
        r_rd_idx     <= '0;
        r_acc        <= '0;
        r_mask       <= '0;
      end else if (r_state == StScore) begin
        r_rd_idx <= r_rd_idx + IdxW'(LANES);
        r_acc    <= r_acc + w_lane_hits;
        r_mask   <= w_mask_d;
        // Published results change only on entry to HOLD.
        if (w_last) begin
          r_hit_cnt  <= r_acc + w_lane_hits;
          r_hit_mask <= w_mask_d;
        end
      end
    end
  end

  assign bus.o_res_valid = (r_state == StHold);
  assign bus.o_busy      = (r_state == StScore);
  assign bus.o_hit_cnt   = r_hit_cnt;
  assign bus.o_hit_mask  = r_hit_mask;
  assign bus.o_err       = r_err;
endmodule

// File: tb/tb_laser_cover_check.sv
// Scoreboard bench for laser_cover_check: driver models frames/acceptance and queues
// expected results; a negedge monitor compares every DUT output every cycle.
module tb_laser_cover_check;
  localparam int N    = 40;
  localparam int LAT  = 40;

  typedef struct {
    int           cnt;
    logic [N-1:0] mask;
    int           t;
    int           vfrom;
  } res_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   vectors;
  int   miscompares;

  res_t         exp_q[$];
  int           err_q[$];
  int           fx[$];
  int           fy[$];
  int           last_cnt;
  logic [N-1:0] last_mask;

  laser_cover_check_if #(.N_TGT(N)) bus ();

  laser_cover_check #(.N_TGT(N), .R2(16), .LANES(1)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int sq(input int a);
    return a * a;
  endfunction

  // Coverage straight from geometry: integer distance squared against radius squared.
  function automatic res_t score(input int a, input int b, input int c, input int d,
                                 input int t);
    res_t r;
    r.cnt  = 0;
    r.mask = '0;
    r.t    = t;
    r.vfrom = t + LAT;
    for (int i = 0; i < N; i++) begin
      if (sq(fx[i] - a) + sq(fy[i] - b) <= 16 || sq(fx[i] - c) + sq(fy[i] - d) <= 16) begin
        r.cnt++;
        r.mask[i] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic drive(input bit tv, input int x, input int y, input bit dn,
                       input int a, input int b, input int c, input int d, input bit rdy);
    int   t;
    bit   full;
    bit   ok;
    res_t r;
    bus.i_tgt_valid = tv;
    bus.i_x         = 4'(x);
    bus.i_y         = 4'(y);
    bus.i_done      = dn;
    bus.i_c1x       = 4'(a);
    bus.i_c1y       = 4'(b);
    bus.i_c2x       = 4'(c);
    bus.i_c2y       = 4'(d);
    bus.i_res_ready = rdy;
    t    = cyc + 1;
    full = (fx.size() == N);
    ok   = dn && full && (exp_q.size() == 0 || (rdy && cyc >= exp_q[0].vfrom));
    if (ok) begin
      r = score(a, b, c, d, t);
      exp_q.push_back(r);
      fx.delete();
      fy.delete();
    end
    if (tv && (ok || !full)) begin
      fx.push_back(x);
      fy.push_back(y);
    end
    if ((dn && !ok) || (tv && full && !ok)) err_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) drive(1'b0, 0, 0, 1'b0, 0, 0, 0, 0, rdy);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    bus.i_tgt_valid = 1'b0;
    bus.i_done      = 1'b0;
    bus.i_res_ready = 1'b0;
    exp_q.delete();
    err_q.delete();
    fx.delete();
    fy.delete();
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load_rand(input int n, input bit rdy);
    repeat (n) drive(1'b1, $urandom_range(15, 0), $urandom_range(15, 0), 1'b0, 0, 0, 0, 0, rdy);
  endtask

  task automatic done_rand(input bit tv, input bit rdy);
    drive(tv, $urandom_range(15, 0), $urandom_range(15, 0), 1'b1, $urandom_range(15, 0),
          $urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(15, 0), rdy);
  endtask

  always @(negedge clk) begin
    bit ev;
    bit eb;
    bit ee;
    if (!rst_n) begin
      last_cnt  = 0;
      last_mask = '0;
      check("rst_res_valid", 64'(bus.o_res_valid), 64'd0);
      check("rst_busy", 64'(bus.o_busy), 64'd0);
      check("rst_err", 64'(bus.o_err), 64'd0);
      check("rst_hit_cnt", 64'(bus.o_hit_cnt), 64'd0);
      check("rst_hit_mask", 64'(bus.o_hit_mask), 64'd0);
    end else begin
      ev = (exp_q.size() > 0) && (cyc >= exp_q[0].vfrom);
      if (ev) begin
        last_cnt  = exp_q[0].cnt;
        last_mask = exp_q[0].mask;
      end
      eb = 1'b0;
      foreach (exp_q[i]) if (cyc >= exp_q[i].t && cyc < exp_q[i].vfrom) eb = 1'b1;
      while (err_q.size() > 0 && err_q[0] < cyc) void'(err_q.pop_front());
      ee = (err_q.size() > 0) && (err_q[0] == cyc);
      if (ee) void'(err_q.pop_front());
      check("res_valid", 64'(bus.o_res_valid), 64'(ev));
      check("busy", 64'(bus.o_busy), 64'(eb));
      check("err", 64'(bus.o_err), 64'(ee));
      check("hit_cnt", 64'(bus.o_hit_cnt), 64'(last_cnt));
      check("hit_mask", 64'(bus.o_hit_mask), 64'(last_mask));
      if (ev && bus.i_res_ready) void'(exp_q.pop_front());
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    last_cnt    = 0;
    last_mask   = '0;
    rst_n       = 1'b0;
    bus.i_tgt_valid = 1'b0;
    bus.i_x = '0;
    bus.i_y = '0;
    bus.i_done = 1'b0;
    bus.i_c1x = '0;
    bus.i_c1y = '0;
    bus.i_c2x = '0;
    bus.i_c2y = '0;
    bus.i_res_ready = 1'b0;
    do_reset(3);

    // All targets at one centre: full coverage.
    repeat (N) drive(1'b1, 8, 8, 1'b0, 0, 0, 0, 0, 1'b0);
    drive(1'b0, 0, 0, 1'b1, 8, 8, 0, 0, 1'b0);
    idle(45, 1'b0);
    idle(2, 1'b1);

    // Radius boundary: distance^2 of 16 hits, 17 misses.
    repeat (20) drive(1'b1, 4, 0, 1'b0, 0, 0, 0, 0, 1'b0);
    repeat (20) drive(1'b1, 4, 1, 1'b0, 0, 0, 0, 0, 1'b0);
    drive(1'b0, 0, 0, 1'b1, 0, 0, 15, 15, 1'b0);
    idle(43, 1'b1);

    // Both circles cover every target: counted once.
    repeat (N) drive(1'b1, 4, 4, 1'b0, 0, 0, 0, 0, 1'b0);
    drive(1'b0, 0, 0, 1'b1, 2, 2, 6, 6, 1'b0);
    idle(43, 1'b1);

    // Short frame rejected, completed frame accepted.
    load_rand(39, 1'b0);
    done_rand(1'b0, 1'b0);
    load_rand(1, 1'b0);
    done_rand(1'b0, 1'b0);
    idle(43, 1'b1);

    // Back-pressure with overlapped load of the next frame.
    load_rand(N, 1'b0);
    done_rand(1'b0, 1'b0);
    load_rand(N, 1'b0);
    load_rand(1, 1'b0);
    idle(60, 1'b0);
    done_rand(1'b0, 1'b0);
    idle(3, 1'b0);
    done_rand(1'b1, 1'b1);
    idle(45, 1'b1);

    // Reset mid-score, then an under-filled DONE.
    load_rand(N - 1, 1'b0);
    done_rand(1'b0, 1'b0);
    idle(10, 1'b0);
    do_reset(2);
    load_rand(5, 1'b0);
    done_rand(1'b0, 1'b0);

    // Random traffic with one more asynchronous reset.
    for (int i = 0; i < 2000; i++) begin
      if (i == 900) do_reset(2);
      drive(($urandom % 4) != 0, $urandom_range(15, 0), $urandom_range(15, 0),
            ($urandom % 12) == 0, $urandom_range(15, 0), $urandom_range(15, 0),
            $urandom_range(15, 0), $urandom_range(15, 0), ($urandom % 3) == 0);
    end
    idle(50, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
